// File: rtl/led_drv_pkg.sv
// Shared constants and helpers for the green-LED fade/blink driver.
package led_drv_pkg;

  localparam int DEF_N_LED        = 7;
  localparam int DEF_LEVEL_W      = 4;
  localparam int DEF_PRESCALE_DIV = 50;
  localparam int DEF_RAMP_FRAMES  = 4;
  localparam int DEF_BLINK_FRAMES = 32;

  typedef enum logic [1:0] {
    RAMP_HOLD,
    RAMP_UP,
    RAMP_DOWN
  } ramp_dir_e;

  function automatic int max_level(input int level_w);
    return (1 << level_w) - 1;
  endfunction

  // Counters that only ever hold 0 still need a 1-bit register.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_fade_channel.sv
// One LED channel: brightness level that steps toward its on/off target,
// compared against the shared PWM counter to drive a registered pin.
module led_fade_channel
  import led_drv_pkg::*;
#(
  parameter int LEVEL_W = DEF_LEVEL_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               target_on,
  input  logic               ramp_tick,
  input  logic [LEVEL_W-1:0] pwm_cnt,
  input  logic               blank,
  output logic               led_out,
  output logic               mismatch
);

  localparam logic [LEVEL_W-1:0] MAX = LEVEL_W'(max_level(LEVEL_W));

  logic [LEVEL_W-1:0] level;
  logic [LEVEL_W-1:0] target;
  ramp_dir_e          dir;

  always_comb begin
    target = target_on ? MAX : '0;
    dir    = RAMP_HOLD;
    if (level < target)
      dir = RAMP_UP;
    else if (level > target)
      dir = RAMP_DOWN;
  end

  assign mismatch = (level != target);

  // Target is sampled live, so a reversal takes effect on the very next ramp_tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level   <= '0;
      led_out <= 1'b0;
    end else begin
      if (ramp_tick) begin
        case (dir)
          RAMP_UP:   level <= level + LEVEL_W'(1);
          RAMP_DOWN: level <= level - LEVEL_W'(1);
          default:   level <= level;
        endcase
      end
      led_out <= (level > pwm_cnt) & ~blank;
    end
  end

endmodule

// File: rtl/led_fade_pwm.sv
// Green-LED output stage: shared prescaler/PWM/ramp/blink timebase feeding
// one fade channel per LED, plus the aggregate busy flag.
module led_fade_pwm
  import led_drv_pkg::*;
#(
  parameter int N_LED        = DEF_N_LED,
  parameter int LEVEL_W      = DEF_LEVEL_W,
  parameter int PRESCALE_DIV = DEF_PRESCALE_DIV,
  parameter int RAMP_FRAMES  = DEF_RAMP_FRAMES,
  parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_LED-1:0] led_req,
  input  logic             enable,
  input  logic             blink_en,
  output logic [N_LED-1:0] led_out,
  output logic             busy
);

  localparam int PS_W    = cnt_width(PRESCALE_DIV);
  localparam int RAMP_W  = cnt_width(RAMP_FRAMES);
  localparam int BLINK_W = cnt_width(BLINK_FRAMES);

  localparam logic [PS_W-1:0]    PS_LAST    = PS_W'(PRESCALE_DIV - 1);
  localparam logic [LEVEL_W-1:0] PWM_LAST   = LEVEL_W'(max_level(LEVEL_W) - 1);
  localparam logic [RAMP_W-1:0]  RAMP_LAST  = RAMP_W'(RAMP_FRAMES - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

  logic [PS_W-1:0]    ps_cnt;
  logic [LEVEL_W-1:0] pwm_cnt;
  logic [RAMP_W-1:0]  ramp_cnt;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;
  logic               pwm_tick;
  logic               frame_wrap;
  logic               ramp_tick;
  logic               blank;
  logic [N_LED-1:0]   mismatch;

  assign pwm_tick   = (ps_cnt == PS_LAST);
  assign frame_wrap = pwm_tick & (pwm_cnt == PWM_LAST);
  assign ramp_tick  = frame_wrap & (ramp_cnt == RAMP_LAST);
  assign blank      = blink_en & blink_phase;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      ps_cnt <= '0;
    else if (pwm_tick)
      ps_cnt <= '0;
    else
      ps_cnt <= ps_cnt + PS_W'(1);
  end

  // A frame is MAX ticks: pwm_cnt runs 0..MAX-1 so level MAX is on every tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      pwm_cnt <= '0;
    else if (frame_wrap)
      pwm_cnt <= '0;
    else if (pwm_tick)
      pwm_cnt <= pwm_cnt + LEVEL_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      ramp_cnt <= '0;
    else if (ramp_tick)
      ramp_cnt <= '0;
    else if (frame_wrap)
      ramp_cnt <= ramp_cnt + RAMP_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_wrap) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BLINK_W'(1);
      end
    end
  end

  for (genvar gi = 0; gi < N_LED; gi++) begin : gen_ch
    led_fade_channel #(
      .LEVEL_W (LEVEL_W)
    ) u_ch (
      .clk       (clk),
      .reset_n   (reset_n),
      .target_on (led_req[gi] & enable),
      .ramp_tick (ramp_tick),
      .pwm_cnt   (pwm_cnt),
      .blank     (blank),
      .led_out   (led_out[gi]),
      .mismatch  (mismatch[gi])
    );
  end

  assign busy = |mismatch;

endmodule

// File: tb/tb_led_fade_pwm.sv
// Directed bench for led_fade_pwm with a 30-cycle frame (PRESCALE_DIV=2,
// LEVEL_W=4, RAMP_FRAMES=1, BLINK_FRAMES=2); edge k counts from reset release.
module tb_led_fade_pwm;

  localparam int N_LED = 7;
  localparam int FRAME = 30;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [N_LED-1:0] led_req = '0;
  logic             enable = 1'b0;
  logic             blink_en = 1'b0;
  logic [N_LED-1:0] led_out;
  logic             busy;

  int checks = 0;
  int errors = 0;

  led_fade_pwm #(
    .N_LED        (N_LED),
    .LEVEL_W      (4),
    .PRESCALE_DIV (2),
    .RAMP_FRAMES  (1),
    .BLINK_FRAMES (2)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .led_req  (led_req),
    .enable   (enable),
    .blink_en (blink_en),
    .led_out  (led_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic [N_LED-1:0] req, input logic en, input logic blk);
    led_req  = req;
    enable   = en;
    blink_en = blk;
  endtask

  task automatic stepEdges(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reset with the given inputs applied; the next posedge after return is edge 1.
  task automatic startFromReset(input string tag, input logic [N_LED-1:0] req, input logic en,
                                input logic blk, input logic exp_busy);
    applyStimulus(req, en, blk);
    reset_n = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_rst_led"}, 32'(led_out), 32'h0);
    checkOutput({tag, "_rst_busy"}, 32'(busy), 32'(exp_busy));
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic countFrame(input int ch, output int ones);
    ones = 0;
    repeat (FRAME) begin
      @(posedge clk);
      #1;
      ones += int'(led_out[ch]);
    end
  endtask

  initial begin
    int d;
    logic [N_LED-1:0] or_led;
    logic or_busy;
    logic all_busy;

    $display("[TB] starting led_fade_pwm bench");

    // Idle: nothing requested, nothing lit
    startFromReset("idle", 7'h00, 1'b1, 1'b0, 1'b0);
    or_led  = '0;
    or_busy = 1'b0;
    repeat (1000) begin
      stepEdges(1);
      or_led  |= led_out;
      or_busy |= busy;
    end
    checkOutput("idle_led", 32'(or_led), 32'h0);
    checkOutput("idle_busy", 32'(or_busy), 32'h0);

    // Ramp up: frame n (edges 30n+1..30n+30) shows level min(n,15) -> 2*level ones
    startFromReset("up", 7'h01, 1'b1, 1'b0, 1'b1);
    for (int n = 0; n <= 16; n++) begin
      countFrame(0, d);
      checkOutput($sformatf("up_duty_f%0d", n), 32'(d), 32'(2 * ((n < 15) ? n : 15)));
      if (n == 13) checkOutput("up_busy_e420", 32'(busy), 32'h1);
      if (n == 14) checkOutput("up_busy_e450", 32'(busy), 32'h0);
    end
    checkOutput("up_other_leds", 32'(led_out[6:1]), 32'h0);

    // Reversal at level 8: windows after edge 240 show levels 8,7,...,0
    startFromReset("rev", 7'h01, 1'b1, 1'b0, 1'b1);
    stepEdges(240);
    applyStimulus(7'h00, 1'b1, 1'b0);
    checkOutput("rev_busy_drop", 32'(busy), 32'h1);
    for (int j = 0; j <= 8; j++) begin
      countFrame(0, d);
      checkOutput($sformatf("rev_duty_w%0d", j), 32'(d), 32'(16 - 2 * j));
      if (j == 6) checkOutput("rev_busy_e450", 32'(busy), 32'h1);
      if (j == 7) checkOutput("rev_busy_e480", 32'(busy), 32'h0);
    end

    // Global disable from full brightness: ramp ticks at 480..900 take 15 -> 0
    startFromReset("dis", 7'h7F, 1'b1, 1'b0, 1'b1);
    stepEdges(450);
    checkOutput("dis_busy_full", 32'(busy), 32'h0);
    stepEdges(5);
    checkOutput("dis_led_full", 32'(led_out), 32'h7F);
    applyStimulus(7'h7F, 1'b0, 1'b0);
    all_busy = 1'b1;
    for (int k = 456; k < 900; k++) begin
      stepEdges(1);
      all_busy &= busy;
    end
    checkOutput("dis_busy_during", 32'(all_busy), 32'h1);
    stepEdges(1);
    checkOutput("dis_busy_done", 32'(busy), 32'h0);
    or_led = led_out;
    repeat (FRAME) begin
      stepEdges(1);
      or_led |= led_out;
    end
    checkOutput("dis_led_off", 32'(or_led), 32'h0);

    // Blink: phase is 1 between edges 420 and 480, 0 until 540, 1 until 600
    startFromReset("blink", 7'h7F, 1'b1, 1'b1, 1'b1);
    stepEdges(450);
    checkOutput("blink_busy_e450", 32'(busy), 32'h0);
    checkOutput("blink_led_e450", 32'(led_out), 32'h00);
    stepEdges(30);
    checkOutput("blink_led_e480", 32'(led_out), 32'h00);
    stepEdges(1);
    checkOutput("blink_led_e481", 32'(led_out), 32'h7F);
    stepEdges(59);
    checkOutput("blink_led_e540", 32'(led_out), 32'h7F);
    stepEdges(1);
    checkOutput("blink_led_e541", 32'(led_out), 32'h00);
    stepEdges(59);
    checkOutput("blink_led_e600", 32'(led_out), 32'h00);
    stepEdges(1);
    checkOutput("blink_led_e601", 32'(led_out), 32'h7F);

    // Async reset at level 6: edge 190 sees pwm_cnt 4 so LED 0 is lit before the pulse
    startFromReset("arst", 7'h01, 1'b1, 1'b0, 1'b1);
    stepEdges(190);
    checkOutput("arst_led_before", 32'(led_out), 32'h01);
    reset_n = 1'b0;
    #1;
    checkOutput("arst_led_now", 32'(led_out), 32'h00);
    checkOutput("arst_busy_now", 32'(busy), 32'h1);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    countFrame(0, d);
    checkOutput("arst_duty_f0", 32'(d), 32'h0);
    countFrame(0, d);
    checkOutput("arst_duty_f1", 32'(d), 32'h2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_fade_pwm.md
# led_fade_pwm

Output stage for the green-LED bank. It consumes the 7-bit LED register output of the green-LED PIO and drives the physical LED pins. Each LED gets a PWM brightness level that ramps smoothly toward on or off. A global blink gate can be applied on top of the ramp. Software keeps writing plain on/off bits; all fading and blinking is done here.

## Interface
- N_LED, 7, number of LED channels
- LEVEL_W, 4, brightness level width; MAX = 2^LEVEL_W-1; legal 2..8
- PRESCALE_DIV, 50, clk cycles per PWM tick; legal >=1 (1 = tick every cycle)
- RAMP_FRAMES, 4, PWM frames per one-step level change; legal >=1
- BLINK_FRAMES, 32, PWM frames per blink half-period; legal >=1

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- led_req  in  N_LED  requested on/off per LED (PIO out_port); same clock domain, no synchronizer
- enable  in  1  global enable; 0 = all targets 0, so every LED fades out
- blink_en  in  1  1 = gate outputs with the blink phase
- led_out  out  N_LED  registered LED pin drive
- busy  out  1  1 while any channel level differs from its target

## Operation
- Prescaler: counts 0..PRESCALE_DIV-1 and wraps. pwm_tick is 1 for one cycle when the count equals PRESCALE_DIV-1.
- PWM counter pwm_cnt (LEVEL_W bits): counts 0..MAX-1 and advances on pwm_tick.
  - A frame is MAX ticks long.
  - frame_wrap = pwm_tick & (pwm_cnt == MAX-1); pwm_cnt goes to 0 on that edge.
- Ramp counter: counts frame_wraps 0..RAMP_FRAMES-1. ramp_tick = frame_wrap & (ramp_cnt == RAMP_FRAMES-1).
- Per channel i:
  - target[i] = (led_req[i] & enable) ? MAX : 0.
  - On ramp_tick, level[i] moves one step toward target[i]: +1 if below, -1 if above, unchanged if equal.
  - No overshoot, no wrap.
- Target changes mid-ramp: target is re-evaluated every cycle. The ramp reverses direction at the next ramp_tick. No restart, no jump.
- Blink counter: counts frame_wraps 0..BLINK_FRAMES-1. blink_phase toggles on the frame_wrap where the count equals BLINK_FRAMES-1.
  - All counters run freely regardless of blink_en and enable.
- Output: led_out[i] <= (level[i] > pwm_cnt) & ~(blink_en & blink_phase).
  - Level 0 is never on. Level MAX is always on (except during the blink-off phase).
  - Level L is on for L of every MAX ticks.
- Blink does not affect level. Ramping continues while blanked.
- busy = OR over i of (level[i] != target[i]). It is combinational from registered state and inputs.

## Timing
- Reset values: prescaler, pwm_cnt, ramp_cnt, blink_cnt, all levels, blink_phase = 0; led_out = 0.
  - busy = 0 only while led_req & enable is 0.
- Asynchronous reset mid-ramp: all state returns to 0 immediately. No fade-out.
- led_out latency:
  - One clk after level/pwm_cnt change.
  - First ramp step at most RAMP_FRAMES frames after the target changes.
- Full on-to-off (or off-to-on) transition: MAX × RAMP_FRAMES frames = MAX² × RAMP_FRAMES × PRESCALE_DIV cycles (defaults: 45000).
- Simultaneous ramp_tick and target change: the new target is used on that edge.
- With PRESCALE_DIV=1, pwm_tick is constantly 1.

## Structure
- Package led_drv_pkg:
  - function max_level(LEVEL_W)
  - default parameter constants
- Sub-module led_fade_channel, instantiated N_LED times:
  - inputs: target bit, ramp_tick, pwm_cnt, blank
  - state: level register
  - outputs: registered led_out bit and mismatch flag
- Top level owns the prescaler, PWM, ramp and blink counters, and the busy OR.

## Test plan
All scenarios use PRESCALE_DIV=2, LEVEL_W=4, RAMP_FRAMES=1, BLINK_FRAMES=2 (frame = 30 cycles) unless noted.
- Reset release with led_req=0, enable=1 -> led_out=0 and busy=0 for 1000 cycles.
- led_req=7'h01 from a frame start:
  - level[0] reaches 15 after 15 frames (450 cycles); busy falls then.
  - led_out[0] duty is L/15 per frame during the ramp, constant 1 afterward.
- Ramp up to level 8, then drop led_req[0] -> level reverses at the next ramp_tick: 8→7→…→0. No step exceeds 1.
- enable 1→0 with all 7 LEDs at 15 -> all fade to 0 in 15 frames; busy is 1 throughout.
- blink_en=1, led_req=7'h7F at full level -> led_out alternates 7'h7F / 7'h00 every 2 frames (60 cycles).
- reset_n pulsed low for 1 cycle mid-ramp at level 6 -> led_out=0 immediately. The ramp restarts from level 0.
